// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, FSM states and baud helpers for the UART TX
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Narrowest counter that still reaches clks_per_bit-1; never below one bit.
  function automatic int baud_cnt_width(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write handshake into the UART transmit queue
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with the head word visible combinationally
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pushes are refused when full even if a pop lands in the same cycle.
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - queued UART transmitter sending frames back-to-back
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_fifo_if.slave                 wr,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = baud_cnt_width(CPB);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr.wr_ready = !fifo_full;
  assign tx_line     = line_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign bit_end     = (baud_cnt_q == CNT_LAST);

  // State and datapath registers; every output is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Frame sequencing; a pop from IDLE or the final stop period starts the next frame at once.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    line_d     = line_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        line_d     = 1'b1;
        busy_d     = 1'b0;
        baud_cnt_d = '0;
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
          line_d     = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              line_d  = par_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              line_d     = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            line_d    = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      PAR: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = STOP;
          stop_idx_d = 1'b0;
          line_d     = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if ((STOP_BITS == 2) && (stop_idx_q == 1'b0)) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
            end else begin
              state_d = IDLE;
              line_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Capture the head word and its parity here so later writes cannot disturb the frame.
    if (fifo_pop) begin
      shift_d    = fifo_head;
      par_d      = (^fifo_head) ^ (PARITY == PAR_ODD);
      baud_cnt_d = '0;
      state_d    = START;
      line_d     = 1'b0;
      busy_d     = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo in 8N1, 7E2 and 8O1 builds
module tb_uart_tx_fifo;

  localparam int CPB = 10;

  typedef struct {
    int          sel;
    logic [15:0] bits;
  } exp_t;

  typedef struct {
    int          sel;
    logic [8:0]  data;
    logic [15:0] exp_bits;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  logic       tx_line_a, tx_busy_a, tx_done_a;
  logic       tx_line_b, tx_busy_b, tx_done_b;
  logic       tx_line_c, tx_busy_c, tx_done_c;
  logic [2:0] fifo_count_a, fifo_count_b, fifo_count_c;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .wr(if_a), .tx_line(tx_line_a), .tx_busy(tx_busy_a),
    .tx_done(tx_done_a), .fifo_count(fifo_count_a));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .wr(if_b), .tx_line(tx_line_b), .tx_busy(tx_busy_b),
    .tx_done(tx_done_b), .fifo_count(fifo_count_b));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .wr(if_c), .tx_line(tx_line_c), .tx_busy(tx_busy_c),
    .tx_done(tx_done_c), .fifo_count(fifo_count_c));

  wire [2:0] line_w = {tx_line_c, tx_line_b, tx_line_a};
  wire [2:0] done_w = {tx_done_c, tx_done_b, tx_done_a};
  wire [2:0] busy_w = {tx_busy_c, tx_busy_b, tx_busy_a};

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference framing: start, LSB-first data, optional parity, stop bits; bit i is the i-th on the line.
  function automatic logic [15:0] model_frame(input logic [8:0] d, input int dbits,
                                              input int par, input int stops);
    logic [15:0] f;
    logic        p;
    int          pos;
    f   = '0;
    p   = 1'b0;
    pos = 1;
    for (int i = 0; i < dbits; i++) begin
      f[pos] = d[i];
      p      = p ^ d[i];
      pos++;
    end
    if (par != 0) begin
      f[pos] = (par == 2) ? p : ~p;
      pos++;
    end
    for (int i = 0; i < stops; i++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic expect_frame(input int sel, input logic [15:0] bits);
    exp_t e;
    e.sel  = sel;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  task automatic check_frame(input int g, input logic [15:0] bits, input logic dbad,
                             input logic dgood);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_frame: dut %0d sent 0x%0h, expected no frame", g, bits);
    end else begin
      e = exp_q.pop_front();
      chk("frame_dut", g, e.sel);
      chk("frame_bits", bits, e.bits);
      chk("done_early", dbad, 0);
      chk("done_at_frame_end", dgood, 1);
    end
  endtask

  // Line monitors: sample mid-bit from the first low cycle and hand completed frames to the scoreboard.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int NB = (g == 0) ? 10 : 11;
    localparam int FL = NB * CPB;
    initial begin : mon
      logic [15:0] bits;
      logic        ab;
      logic        dbad;
      logic        dgood;
      @(negedge clk);
      forever begin
        if (line_w[g] == 1'b0 && !reset) begin
          bits  = '0;
          ab    = 1'b0;
          dbad  = 1'b0;
          dgood = 1'b0;
          for (int k = 0; k <= FL; k++) begin
            if (k > 0) @(negedge clk);
            if (reset) ab = 1'b1;
            if ((k % CPB) == CPB / 2 && (k / CPB) < NB) bits[k / CPB] = line_w[g];
            if (k == FL - 1) dbad = done_w[g];
            if (k == FL) dgood = done_w[g];
          end
          if (!ab) check_frame(g, bits, dbad, dgood);
        end else begin
          @(negedge clk);
        end
      end
    end
  end

  task automatic push_one(input int sel, input logic [8:0] d);
    @(negedge clk);
    case (sel)
      0:       begin if_a.wr_data = d[7:0]; if_a.wr_valid = 1'b1; end
      1:       begin if_b.wr_data = d[6:0]; if_b.wr_valid = 1'b1; end
      default: begin if_c.wr_data = d[7:0]; if_c.wr_valid = 1'b1; end
    endcase
    @(negedge clk);
    if_a.wr_valid = 1'b0;
    if_b.wr_valid = 1'b0;
    if_c.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_w != 3'b000) && n < max) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= max) begin
      fails++;
      $display("FAIL idle_timeout: %0d frames pending after %0d cycles, expected 0", exp_q.size(), n);
    end
  endtask

  vec_t        vecs [7];
  logic [7:0]  bvals [6];

  initial begin
    int   idx, n, ndone, drops, last_done, lows;
    logic r, refused_seen;

    vecs[0] = '{0, 9'h000, 16'h0200};
    vecs[1] = '{0, 9'h0FF, 16'h03FE};
    vecs[2] = '{0, 9'h03C, 16'h0278};
    vecs[3] = '{1, 9'h035, 16'h066A};
    vecs[4] = '{1, 9'h001, 16'h0702};
    vecs[5] = '{2, 9'h000, 16'h0600};
    vecs[6] = '{2, 9'h0FF, 16'h07FE};
    bvals   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    if_a.wr_valid = 1'b0; if_a.wr_data = '0;
    if_b.wr_valid = 1'b0; if_b.wr_data = '0;
    if_c.wr_valid = 1'b0; if_c.wr_data = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_line", tx_line_a, 1);
    chk("reset_busy", tx_busy_a, 0);
    chk("reset_done", tx_done_a, 0);
    chk("reset_count", fifo_count_a, 0);
    chk("reset_ready", if_a.wr_ready, 1);
    chk("reset_line_b", tx_line_b, 1);

    // First-bit latency and frame length for 0xA5 in 8N1.
    expect_frame(0, 16'h034A);
    push_one(0, 9'h0A5);
    chk("lat_line_after_push", tx_line_a, 1);
    chk("lat_count_after_push", fifo_count_a, 1);
    @(negedge clk);
    chk("lat_line_low", tx_line_a, 0);
    chk("lat_busy", tx_busy_a, 1);
    chk("lat_count_popped", fifo_count_a, 0);
    n = 0;
    while (!tx_done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_cycles_to_done", n, 100);
    chk("busy_after_done", tx_busy_a, 0);
    wait_idle(300);

    for (int i = 0; i < 7; i++) begin
      expect_frame(vecs[i].sel, vecs[i].exp_bits);
      push_one(vecs[i].sel, vecs[i].data);
      wait_idle(300);
    end

    // Burst of six with valid held: five accepted, sixth refused at the full-FIFO pop edge.
    @(negedge clk);
    idx = 0;
    if_a.wr_data  = bvals[0];
    if_a.wr_valid = 1'b1;
    n = 0;
    while (idx < 5 && n < 50) begin
      r = if_a.wr_ready;
      @(negedge clk);
      n++;
      if (r) begin
        expect_frame(0, model_frame({1'b0, bvals[idx]}, 8, 0, 1));
        idx++;
        if_a.wr_data = bvals[idx];
      end
    end
    chk("burst_accepted", idx, 5);
    chk("burst_full_count", fifo_count_a, 4);
    chk("burst_full_ready", if_a.wr_ready, 0);

    ndone = 0; drops = 0; last_done = 0; refused_seen = 1'b0; n = 0;
    while (ndone < 5 && n < 700) begin
      @(negedge clk);
      n++;
      if (tx_done_a) begin
        if (ndone > 0) chk("done_spacing", cyc - last_done, 100);
        last_done = cyc;
        ndone++;
      end
      if (!refused_seen && fifo_count_a != 3'd4) begin
        chk("full_pop_count", fifo_count_a, 3);
        chk("full_pop_done", tx_done_a, 1);
        if_a.wr_valid = 1'b0;
        refused_seen = 1'b1;
      end
      if (ndone < 5 && !tx_busy_a) drops++;
    end
    if_a.wr_valid = 1'b0;
    chk("full_pop_seen", refused_seen, 1);
    chk("burst_done_pulses", ndone, 5);
    chk("burst_busy_drops", drops, 0);
    wait_idle(300);

    // Reset in the middle of DATA with two characters queued.
    push_one(0, 9'h05A);
    push_one(0, 9'h0C3);
    push_one(0, 9'h07E);
    repeat (30) @(negedge clk);
    chk("pre_reset_count", fifo_count_a, 2);
    chk("pre_reset_busy", tx_busy_a, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_line", tx_line_a, 1);
    chk("mid_reset_busy", tx_busy_a, 0);
    chk("mid_reset_count", fifo_count_a, 0);
    chk("mid_reset_done", tx_done_a, 0);
    #1 reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (!tx_line_a || tx_busy_a) lows++;
    end
    chk("post_reset_quiet", lows, 0);
    chk("post_reset_count", fifo_count_a, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
